// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built from two half_adder cells and an OR gate.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement subtraction.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_c,
    output logic carry_c
);
    assign sum_c   = a_i ^ b_i;
    assign carry_c = a_i & b_i;
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               s1_c, c1_c, sbit_c, c2_c, carry_nxt_c, sub_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    // Full-adder core: two half adders plus the carry OR
    half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .sum_c(s1_c),   .carry_c(c1_c));
    half_adder u_ha1 (.a_i(s1_c),   .b_i(carry_q), .sum_c(sbit_c), .carry_c(c2_c));
    assign carry_nxt_c = c1_c | c2_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction: invert B and seed carry with 1
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub_c}};
                    carry_d = sub_c;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d   = {sbit_c, acc_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = carry_nxt_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sum_d   = acc_d;
                    cout_d  = carry_nxt_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected {cout,sum},
// a negedge monitor pops and compares on every done pulse.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_r;
`endif

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned done_cnt  = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  last_res  = '0;

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub  (sub_r),
`endif
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_sub(input logic v);
`ifdef SERIAL_ADDER_SUB_EN
        sub_r = v;
`endif
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_done: got %0h, expected no done", {cout, sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} === e) pass_cnt++;
                else $display("FAIL result: got %0h, expected %0h", {cout, sum}, e);
            end
        end
    end

    // One full operation from IDLE, with timing checks along the way
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         input logic [8:0] exp, input string name);
        int cyc;
        int unsigned d0;
        d0 = done_cnt;
        start = 1'b1; a = av; b = bv; set_sub(sv);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); set_sub(1'($urandom));
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        check({name, "_sum_hold"}, 32'({cout, sum}), 32'(last_res));
        cyc = 1;
        while (busy === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            if (busy === 1'b1) cyc++;
        end
        check({name, "_busy_cycles"}, 32'(cyc), 32'd8);
        check({name, "_done_hi"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        last_res = exp;
    endtask

    initial begin
        int unsigned d0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; set_sub(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h5A, 8'h3C, 1'b0, 9'h096, "basic");
        do_op(8'hFF, 8'h01, 1'b0, 9'h100, "carry1");
        do_op(8'hFF, 8'hFF, 1'b0, 9'h1FE, "carryff");
        do_op(8'h00, 8'h00, 1'b0, 9'h000, "zero");

        // Start while busy is ignored
        d0 = done_cnt;
        start = 1'b1; a = 8'h01; b = 8'h02;
        exp_q.push_back(9'h003);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; a = 8'h80; b = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle", 32'(busy), 32'd0);
        last_res = 9'h003;

        // Back-to-back with start held high
        d0 = done_cnt;
        start = 1'b1; a = 8'h10; b = 8'h20;
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h080);
        @(posedge clk); #1;
        a = 8'h7F; b = 8'h01;
        repeat (8) begin @(posedge clk); #1; end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("b2b_busy_rise", 32'(busy), 32'd1);
        check("b2b_done_fall", 32'(done), 32'd0);
        start = 1'b0; a = 8'hC3; b = 8'h3C;
        repeat (8) begin @(posedge clk); #1; end
        check("b2b_done2", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        last_res = 9'h080;

        // Reset mid-SHIFT aborts without a done
        start = 1'b1; a = 8'hAA; b = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        last_res = 9'h000;
        do_op(8'h05, 8'h06, 1'b0, 9'h00B, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 9'h10F, "sub_nb");
        do_op(8'h01, 8'h02, 1'b1, 9'h0FF, "sub_borrow");
        do_op(8'h33, 8'h44, 1'b0, 9'h077, "sub_off_add");
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
